// File: rtl/operand_latch_if.sv
// Operand latch bus: raw switch/button inputs and latched operand outputs.
// The master drives the raw inputs; the slave is the latch itself.
interface operand_latch_if;
  logic [7:0] sw;
  logic       btn;
  logic [3:0] A;
  logic [3:0] B;
  logic       load_pulse;
  logic       loaded;
  logic       sw_pending;

  modport master (
    output sw,
    output btn,
    input  A,
    input  B,
    input  load_pulse,
    input  loaded,
    input  sw_pending
  );

  modport slave (
    input  sw,
    input  btn,
    output A,
    output B,
    output load_pulse,
    output loaded,
    output sw_pending
  );
endinterface

// File: rtl/operand_latch.sv
// Synchronizes and debounces the operand switches and the load button,
// latching the accepted switch value into A/B once per debounced press.
module operand_latch #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input logic           clk,
  input logic           reset,
  operand_latch_if.slave bus
);

  localparam int unsigned CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  logic [7:0]    sw_meta;
  logic [7:0]    sw_sync;
  logic [7:0]    sw_cand;
  logic [7:0]    sw_stable;
  logic [CW-1:0] sw_cnt;

  logic          btn_meta;
  logic          btn_sync;
  logic [CW-1:0] btn_cnt;
  logic [CW-1:0] btn_cnt_d;

  btn_state_t    state_q;
  btn_state_t    state_d;
  logic          load_d;

  logic [3:0]    a_q;
  logic [3:0]    b_q;
  logic          load_pulse_q;
  logic          loaded_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sw_meta  <= bus.sw;
      sw_sync  <= sw_meta;
      btn_meta <= bus.btn;
      btn_sync <= btn_meta;
    end
  end

  // Counter holds at CMAX once the candidate is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_cand   <= '0;
      sw_stable <= '0;
      sw_cnt    <= '0;
    end else if (sw_sync != sw_cand) begin
      sw_cand <= sw_sync;
      sw_cnt  <= '0;
    end else if (sw_cand != sw_stable) begin
      if (sw_cnt == CMAX)
        sw_stable <= sw_cand;
      else
        sw_cnt <= sw_cnt + CW'(1);
    end
  end

  assign bus.sw_pending = (sw_cand != sw_stable);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RELEASED;
      btn_cnt <= '0;
    end else begin
      state_q <= state_d;
      btn_cnt <= btn_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    btn_cnt_d = btn_cnt;
    load_d    = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (btn_sync) begin
          state_d   = PRESS_WAIT;
          btn_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = RELEASED;
        end else if (btn_cnt == CMAX) begin
          state_d = PRESSED;
          load_d  = 1'b1;
        end else begin
          btn_cnt_d = btn_cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_d   = RELEASE_WAIT;
          btn_cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_d = PRESSED;
        end else if (btn_cnt == CMAX) begin
          state_d = RELEASED;
        end else begin
          btn_cnt_d = btn_cnt + CW'(1);
        end
      end
      default: begin
        state_d   = RELEASED;
        btn_cnt_d = '0;
      end
    endcase
  end

  // sw_stable is read pre-edge, so a same-edge acceptance is not captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q          <= '0;
      b_q          <= '0;
      load_pulse_q <= 1'b0;
      loaded_q     <= 1'b0;
    end else begin
      load_pulse_q <= load_d;
      if (load_d) begin
        a_q      <= sw_stable[3:0];
        b_q      <= sw_stable[7:4];
        loaded_q <= 1'b1;
      end
    end
  end

  assign bus.A          = a_q;
  assign bus.B          = b_q;
  assign bus.load_pulse = load_pulse_q;
  assign bus.loaded     = loaded_q;

endmodule

// File: tb/tb_operand_latch.sv
// Self-checking bench for operand_latch with a short debounce window.
// Expected loads are queued at stimulus time and checked on load_pulse.
module tb_operand_latch;

  localparam int unsigned DC  = 4;
  localparam int          LAT = DC + 3;

  logic clk = 1'b0;
  logic reset;

  operand_latch_if bus ();

  operand_latch #(
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
  } exp_t;

  typedef struct {
    logic [7:0] sw;
    logic [3:0] a;
    logic [3:0] b;
  } vec_t;

  exp_t sbq[$];
  int   cyc        = 0;
  int   n_cmp      = 0;
  int   n_err      = 0;
  int   pulses     = 0;
  int   last_pulse = -1;
  bit   pend_seen  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.sw_pending === 1'b1) pend_seen = 1'b1;
    if (bus.load_pulse === 1'b1) begin
      pulses++;
      last_pulse = cyc;
      if (sbq.size() == 0) begin
        check("unexpected_load", 1, 0);
      end else begin
        e = sbq.pop_front();
        check("load_A", int'(bus.A), int'(e.a));
        check("load_B", int'(bus.B), int'(e.b));
        check("loaded_at_load", int'(bus.loaded), 1);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(int hold, int rel, output int k);
    bus.btn = 1'b1;
    k = cyc;
    tick(hold);
    bus.btn = 1'b0;
    tick(rel);
  endtask

  initial begin : stim
    vec_t vt[5];
    int   k;
    int   p0;

    vt[0] = '{8'h5A, 4'hA, 4'h5};
    vt[1] = '{8'hFF, 4'hF, 4'hF};
    vt[2] = '{8'h00, 4'h0, 4'h0};
    vt[3] = '{8'h81, 4'h1, 4'h8};
    vt[4] = '{8'hC3, 4'h3, 4'hC};

    reset   = 1'b1;
    bus.sw  = 8'h00;
    bus.btn = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(20);
    check("idle_A", int'(bus.A), 0);
    check("idle_B", int'(bus.B), 0);
    check("idle_loaded", int'(bus.loaded), 0);
    check("idle_pulses", pulses, 0);
    check("idle_pending", int'(bus.sw_pending), 0);

    for (int i = 0; i < 5; i++) begin
      bus.sw = vt[i].sw;
      tick(10);
      check("vec_pending_settled", int'(bus.sw_pending), 0);
      p0 = pulses;
      sbq.push_back('{vt[i].a, vt[i].b});
      press(12, 12, k);
      check("vec_one_pulse", pulses - p0, 1);
      check("vec_latency", last_pulse, k + LAT);
      check("vec_A_held", int'(bus.A), int'(vt[i].a));
      check("vec_B_held", int'(bus.B), int'(vt[i].b));
      check("vec_loaded", int'(bus.loaded), 1);
    end

    p0 = pulses;
    repeat (8) begin
      bus.btn = 1'b1;
      tick(2);
      bus.btn = 1'b0;
      tick(2);
    end
    tick(10);
    check("glitch_no_pulse", pulses - p0, 0);
    check("glitch_A", int'(bus.A), 4'h3);
    check("glitch_B", int'(bus.B), 4'hC);

    bus.sw = 8'h5A;
    tick(10);
    sbq.push_back('{4'hA, 4'h5});
    press(12, 12, k);
    pend_seen = 1'b0;
    p0 = pulses;
    repeat (5) begin
      bus.sw = 8'h33;
      tick(2);
      bus.sw = 8'h5A;
      tick(2);
    end
    bus.sw = 8'h33;
    check("bounce_pending_seen", int'(pend_seen), 1);
    check("bounce_A_kept", int'(bus.A), 4'hA);
    check("bounce_B_kept", int'(bus.B), 4'h5);
    tick(10);
    check("bounce_no_pulse", pulses - p0, 0);
    sbq.push_back('{4'h3, 4'h3});
    press(12, 12, k);
    check("bounce_A_after", int'(bus.A), 4'h3);
    check("bounce_B_after", int'(bus.B), 4'h3);

    bus.sw  = 8'h12;
    bus.btn = 1'b1;
    k = cyc;
    sbq.push_back('{4'h3, 4'h3});
    tick(12);
    bus.btn = 1'b0;
    tick(12);
    check("same_edge_latency", last_pulse, k + LAT);
    check("same_edge_A_old", int'(bus.A), 4'h3);
    check("same_edge_settled", int'(bus.sw_pending), 0);
    sbq.push_back('{4'h2, 4'h1});
    press(12, 12, k);
    check("same_edge_next_B", int'(bus.B), 4'h1);

    p0 = pulses;
    sbq.push_back('{4'h2, 4'h1});
    sbq.push_back('{4'h2, 4'h1});
    bus.btn = 1'b1;
    tick(50);
    bus.btn = 1'b0;
    tick(10);
    bus.btn = 1'b1;
    tick(10);
    bus.btn = 1'b0;
    tick(12);
    check("hold_two_pulses", pulses - p0, 2);

    bus.sw = 8'h7E;
    tick(10);
    p0 = pulses;
    bus.btn = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(2);
    check("rst_A", int'(bus.A), 0);
    check("rst_B", int'(bus.B), 0);
    check("rst_loaded", int'(bus.loaded), 0);
    check("rst_no_pulse", pulses - p0, 0);
    reset = 1'b0;
    k = cyc;
    sbq.push_back('{4'h0, 4'h0});
    tick(4);
    check("rst_sw_pending", int'(bus.sw_pending), 1);
    tick(8);
    bus.btn = 1'b0;
    tick(12);
    check("rst_one_pulse", pulses - p0, 1);
    check("rst_latency", last_pulse, k + LAT);
    check("rst_loaded_after", int'(bus.loaded), 1);
    check("rst_pending_clear", int'(bus.sw_pending), 0);
    sbq.push_back('{4'hE, 4'h7});
    press(12, 12, k);
    check("final_A", int'(bus.A), 4'hE);
    check("final_B", int'(bus.B), 4'h7);

    check("queue_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_latch.md
OPERAND_LATCH -- requirements
Module: operand_latch

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), number of consecutive stable synchronized samples required to accept a level change; legal range >= 1; benches override with a small value.
REQ-002 Port: clk  input  1  100 MHz board clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset (driven from btnC at top level).
REQ-004 Port: sw  input  8  raw asynchronous switches; sw[3:0] = operand A, sw[7:4] = operand B.
REQ-005 Port: btn  input  1  raw asynchronous load pushbutton, active-high.
REQ-006 Port: A  output  4  latched operand A, registered; feeds math block and decoder A input.
REQ-007 Port: B  output  4  latched operand B, registered; feeds math block and decoder B input.
REQ-008 Port: load_pulse  output  1  single-cycle strobe, high in the cycle A/B take new values.
REQ-009 Port: loaded  output  1  high once at least one load has occurred since reset.
REQ-010 Port: sw_pending  output  1  high while a switch change is being debounced.

Function
REQ-011 sw and btn SHALL each pass through a two-flop synchronizer (sw_sync, btn_sync) before any other use.
REQ-012 Switch debounce: candidate register sw_cand and accepted register sw_stable; if sw_sync != sw_cand then sw_cand <= sw_sync and counter <= 0; else if sw_cand != sw_stable then counter increments, and on the edge where counter == DEBOUNCE_CYCLES-1, sw_stable <= sw_cand.
REQ-013 sw_pending SHALL be combinationally (sw_cand != sw_stable).
REQ-014 Button FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT, with its own counter separate from the switch counter.
REQ-015 RELEASED: btn_sync=1 -> PRESS_WAIT, counter <= 0; else stay.
REQ-016 PRESS_WAIT: btn_sync=0 -> RELEASED (glitch rejected, no load); counter == DEBOUNCE_CYCLES-1 with btn_sync=1 -> PRESSED; else counter increments.
REQ-017 PRESSED: btn_sync=0 -> RELEASE_WAIT, counter <= 0; else stay (holding the button SHALL NOT produce further loads).
REQ-018 RELEASE_WAIT: btn_sync=1 -> PRESSED (no load); counter == DEBOUNCE_CYCLES-1 with btn_sync=0 -> RELEASED; else counter increments.
REQ-019 On the PRESS_WAIT -> PRESSED edge only: A <= sw_stable[3:0], B <= sw_stable[7:4], load_pulse <= 1, loaded <= 1; load_pulse SHALL be 0 in all other cycles.
REQ-020 Latency: with btn held high, if E0 is the first edge sampling btn=1, load_pulse SHALL be high for exactly the cycle following edge E0+DEBOUNCE_CYCLES+2.
REQ-021 Load uses sw_stable, not sw_sync; a switch still bouncing or pending at load time SHALL latch the previous accepted value.
REQ-022 Switch changes alone SHALL never alter A, B, or load_pulse.
REQ-023 Counters SHALL saturate/stop at DEBOUNCE_CYCLES-1 and never wrap; counter width is sufficient for DEBOUNCE_CYCLES-1.
REQ-024 Simultaneous switch acceptance and button acceptance on the same edge: the load SHALL capture sw_stable as it was before that edge.

Reset
REQ-025 While reset=1 at an edge: synchronizers, sw_cand, sw_stable, both counters, A, B, load_pulse, loaded SHALL all become 0 and FSM SHALL become RELEASED.
REQ-026 Reset asserted mid-debounce (any state) SHALL abort it with no load_pulse.
REQ-027 Button held through reset release SHALL be treated as a new press: full debounce, then one load.
REQ-028 Switches non-zero at reset release SHALL be debounced into sw_stable normally (sw_pending high meanwhile).

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Reset, sw=8'h00, btn=0 for 20 cycles -> A=0, B=0, loaded=0, load_pulse never high.
REQ-030 sw=8'h5A held 10 cycles, then btn high 12 cycles -> exactly one load_pulse, in the cycle after edge E0+6; A=4'hA, B=4'h5, loaded=1.
REQ-031 btn pulses high 2 cycles / low 2 cycles repeatedly -> no load_pulse; A, B unchanged.
REQ-032 Loaded with 8'h5A, then sw toggles 8'h33/8'h5A every 2 cycles, settles at 8'h33, btn pressed -> sw_pending high during toggling; A=4'h3, B=4'h3 after load.
REQ-033 btn held 50 cycles, released 10, held again 10 -> exactly two load_pulses total.
REQ-034 reset asserted during PRESS_WAIT -> no load_pulse, A/B=0; btn still held after release -> one load E0+6 after first post-reset sample.
